// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the 5-stage datapath (master) and the hazard controller (slave).
// Carries hazard sources, stage load enables/bubble strobes, halt flag and perf counters.
interface pipe_hazard_ctrl_if;
  logic [4:0]  rs1_id;
  logic [4:0]  rs2_id;
  logic [4:0]  rd_ex;
  logic        load_ex;
  logic        mem_req;
  logic        mem_ready;
  logic        br_taken;

  logic        enb_pc;
  logic        enb_1;
  logic        enb_2;
  logic        enb_3;
  logic        enb_4;
  logic        bubble_1;
  logic        bubble_2;
  logic        bubble_4;
  logic        halted;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  modport master (
    output rs1_id, rs2_id, rd_ex, load_ex, mem_req, mem_ready, br_taken,
    input  enb_pc, enb_1, enb_2, enb_3, enb_4,
    input  bubble_1, bubble_2, bubble_4, halted, stall_cnt, flush_cnt
  );

  modport slave (
    input  rs1_id, rs2_id, rd_ex, load_ex, mem_req, mem_ready, br_taken,
    output enb_pc, enb_1, enb_2, enb_3, enb_4,
    output bubble_1, bubble_2, bubble_4, halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller: load-use, data-memory wait and taken-branch handling with timeout halt.
// Define PIPE_HAZARD_CTRL_PERF_EN to build the stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255
) (
  input logic              cpu_clk,
  input logic              reset,
  pipe_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MWAIT = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [15:0] WCNT_LAST = 16'(MEM_TIMEOUT - 1);

  state_t      state_reg;
  logic [15:0] wcnt_reg;
  logic        halted_reg;

  logic mstall;
  logic luh;
  logic flush_apply;
  logic enb_pc, enb_1, enb_2, enb_3, enb_4;
  logic bubble_1, bubble_2, bubble_4;

  always_comb begin
    mstall = hz.mem_req & ~hz.mem_ready;
    luh    = hz.load_ex & (hz.rd_ex != 5'd0) &
             ((hz.rd_ex == hz.rs1_id) | (hz.rd_ex == hz.rs2_id));
  end

  // Mealy decode; reset forces everything quiet even before the flops settle.
  always_comb begin
    enb_pc      = 1'b0;
    enb_1       = 1'b0;
    enb_2       = 1'b0;
    enb_3       = 1'b0;
    enb_4       = 1'b0;
    bubble_1    = 1'b0;
    bubble_2    = 1'b0;
    bubble_4    = 1'b0;
    flush_apply = 1'b0;
    if (reset || state_reg == HALT) begin
      enb_pc = 1'b0;
    end else if (mstall) begin
      // Only write-back advances, and it takes a NOP so the last writeback is not replayed.
      enb_4    = 1'b1;
      bubble_4 = 1'b1;
    end else if (hz.br_taken) begin
      enb_pc      = 1'b1;
      enb_1       = 1'b1;
      enb_2       = 1'b1;
      enb_3       = 1'b1;
      enb_4       = 1'b1;
      bubble_1    = 1'b1;
      bubble_2    = 1'b1;
      flush_apply = 1'b1;
    end else if (luh) begin
      enb_2    = 1'b1;
      enb_3    = 1'b1;
      enb_4    = 1'b1;
      bubble_2 = 1'b1;
    end else begin
      enb_pc = 1'b1;
      enb_1  = 1'b1;
      enb_2  = 1'b1;
      enb_3  = 1'b1;
      enb_4  = 1'b1;
    end
  end

  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      state_reg  <= RUN;
      wcnt_reg   <= '0;
      halted_reg <= 1'b0;
    end else begin
      case (state_reg)
        RUN, MWAIT: begin
          if (mstall) begin
            if (wcnt_reg == WCNT_LAST) begin
              state_reg  <= HALT;
              halted_reg <= 1'b1;
            end else begin
              state_reg <= MWAIT;
            end
            wcnt_reg <= wcnt_reg + 16'd1;
          end else begin
            state_reg <= RUN;
            wcnt_reg  <= '0;
          end
        end
        HALT: begin
          state_reg  <= HALT;
          halted_reg <= 1'b1;
        end
        default: begin
          state_reg  <= RUN;
          wcnt_reg   <= '0;
          halted_reg <= 1'b0;
        end
      endcase
    end
  end

  assign hz.enb_pc   = enb_pc;
  assign hz.enb_1    = enb_1;
  assign hz.enb_2    = enb_2;
  assign hz.enb_3    = enb_3;
  assign hz.enb_4    = enb_4;
  assign hz.bubble_1 = bubble_1;
  assign hz.bubble_2 = bubble_2;
  assign hz.bubble_4 = bubble_4;
  assign hz.halted   = halted_reg;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  // Index 0 counts PC-hold cycles, index 1 counts applied branch flushes.
  logic [1:0]  perf_inc;
  logic [31:0] perf_cnt [2];

  assign perf_inc[0] = ~enb_pc & (state_reg != HALT);
  assign perf_inc[1] = flush_apply;

  for (genvar gi = 0; gi < 2; gi++) begin : g_perf
    logic [31:0] cnt_reg;
    always_ff @(posedge cpu_clk or posedge reset) begin
      if (reset) begin
        cnt_reg <= '0;
      end else if (perf_inc[gi]) begin
        cnt_reg <= cnt_reg + 32'd1;
      end
    end
    assign perf_cnt[gi] = cnt_reg;
  end

  assign hz.stall_cnt = perf_cnt[0];
  assign hz.flush_cnt = perf_cnt[1];
`else
  assign hz.stall_cnt = '0;
  assign hz.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MEM_TIMEOUT = 4); output vector order is
// {enb_pc, enb_1, enb_2, enb_3, enb_4, bubble_1, bubble_2, bubble_4, halted}.
module tb_pipe_hazard_ctrl;

  localparam logic [8:0] EXP_RST  = 9'b00000_000_0;
  localparam logic [8:0] EXP_IDLE = 9'b11111_000_0;
  localparam logic [8:0] EXP_LUH  = 9'b00111_010_0;
  localparam logic [8:0] EXP_MST  = 9'b00001_001_0;
  localparam logic [8:0] EXP_BR   = 9'b11111_110_0;
  localparam logic [8:0] EXP_HALT = 9'b00000_000_1;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic cpu_clk;
  logic reset;
  int   errors;
  int   checks;
  logic [31:0] exp_stall;
  logic [31:0] exp_flush;

  pipe_hazard_ctrl_if hz ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .cpu_clk (cpu_clk),
    .reset   (reset),
    .hz      (hz)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  function automatic logic [8:0] outs();
    return {hz.enb_pc, hz.enb_1, hz.enb_2, hz.enb_3, hz.enb_4,
            hz.bubble_1, hz.bubble_2, hz.bubble_4, hz.halted};
  endfunction

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic ld, input logic mreq, input logic mrdy, input logic br);
    hz.rs1_id    = rs1;
    hz.rs2_id    = rs2;
    hz.rd_ex     = rd;
    hz.load_ex   = ld;
    hz.mem_req   = mreq;
    hz.mem_ready = mrdy;
    hz.br_taken  = br;
  endtask

  task automatic show(input string name);
    $display("[%0t] %-16s outs=%b stall_cnt=%0d flush_cnt=%0d", $time, name, outs(),
             hz.stall_cnt, hz.flush_cnt);
  endtask

  task automatic test_reset();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #2;
    show("reset_idle");
    checks++; if (outs() !== EXP_RST) begin errors++; $display("FAIL reset_outs: got %b expected %b", outs(), EXP_RST); end
    checks++; if (hz.stall_cnt !== 32'd0 || hz.flush_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", hz.stall_cnt, hz.flush_cnt); end
    tick();
    drive(5'd3, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    #1;
    show("reset_events");
    checks++; if (outs() !== EXP_RST) begin errors++; $display("FAIL reset_events: got %b expected %b", outs(), EXP_RST); end
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 reset = 1'b0;
    exp_stall = 0;
    exp_flush = 0;
    tick();
    #3;
    show("post_reset");
    checks++; if (outs() !== EXP_IDLE) begin errors++; $display("FAIL post_reset: got %b expected %b", outs(), EXP_IDLE); end
  endtask

  task automatic test_load_use();
    tick(); drive(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0); #3;
    show("luh_rs1");
    checks++; if (outs() !== EXP_LUH) begin errors++; $display("FAIL luh_rs1: got %b expected %b", outs(), EXP_LUH); end
    exp_stall += 32'(PERF);
    tick(); drive(5'd1, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0); #3;
    show("luh_release");
    checks++; if (outs() !== EXP_IDLE) begin errors++; $display("FAIL luh_release: got %b expected %b", outs(), EXP_IDLE); end
    tick(); drive(5'd2, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0); #3;
    show("luh_rs2");
    checks++; if (outs() !== EXP_LUH) begin errors++; $display("FAIL luh_rs2: got %b expected %b", outs(), EXP_LUH); end
    exp_stall += 32'(PERF);
    tick(); drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0); #3;
    show("luh_x0");
    checks++; if (outs() !== EXP_IDLE) begin errors++; $display("FAIL luh_x0: got %b expected %b", outs(), EXP_IDLE); end
    tick(); drive(5'd9, 5'd0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0); #3;
    show("luh_nonload");
    checks++; if (outs() !== EXP_IDLE) begin errors++; $display("FAIL luh_nonload: got %b expected %b", outs(), EXP_IDLE); end
    tick(); drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); #3;
    show("luh_count");
    checks++; if (hz.stall_cnt !== exp_stall) begin errors++; $display("FAIL luh_stall_cnt: got %0d expected %0d", hz.stall_cnt, exp_stall); end
  endtask

  task automatic test_mem_wait();
    for (int i = 0; i < 3; i++) begin
      tick(); drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); #3;
      show("mwait");
      checks++; if (outs() !== EXP_MST) begin errors++; $display("FAIL mwait_%0d: got %b expected %b", i, outs(), EXP_MST); end
      exp_stall += 32'(PERF);
    end
    tick(); drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0); #3;
    show("mwait_done");
    checks++; if (outs() !== EXP_IDLE) begin errors++; $display("FAIL mwait_done: got %b expected %b", outs(), EXP_IDLE); end
    tick(); drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); #3;
    show("mwait_count");
    checks++; if (hz.stall_cnt !== exp_stall) begin errors++; $display("FAIL mwait_stall_cnt: got %0d expected %0d", hz.stall_cnt, exp_stall); end
  endtask

  task automatic test_branch_luh();
    tick(); drive(5'd3, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1); #3;
    show("br_luh");
    checks++; if (outs() !== EXP_BR) begin errors++; $display("FAIL br_luh: got %b expected %b", outs(), EXP_BR); end
    exp_flush += 32'(PERF);
    tick(); drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); #3;
    show("br_after");
    checks++; if (outs() !== EXP_IDLE) begin errors++; $display("FAIL br_after: got %b expected %b", outs(), EXP_IDLE); end
    checks++; if (hz.flush_cnt !== exp_flush || hz.stall_cnt !== exp_stall) begin errors++; $display("FAIL br_counts: got %0d/%0d expected %0d/%0d", hz.stall_cnt, hz.flush_cnt, exp_stall, exp_flush); end
  endtask

  task automatic test_branch_during_stall();
    for (int i = 0; i < 2; i++) begin
      tick(); drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1); #3;
      show("br_in_mwait");
      checks++; if (outs() !== EXP_MST) begin errors++; $display("FAIL br_in_mwait_%0d: got %b expected %b", i, outs(), EXP_MST); end
      exp_stall += 32'(PERF);
    end
    tick(); drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1); #3;
    show("br_on_ready");
    checks++; if (outs() !== EXP_BR) begin errors++; $display("FAIL br_on_ready: got %b expected %b", outs(), EXP_BR); end
    exp_flush += 32'(PERF);
    tick(); drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); #3;
    show("br_stall_count");
    checks++; if (outs() !== EXP_IDLE) begin errors++; $display("FAIL br_stall_idle: got %b expected %b", outs(), EXP_IDLE); end
    checks++; if (hz.flush_cnt !== exp_flush || hz.stall_cnt !== exp_stall) begin errors++; $display("FAIL br_stall_counts: got %0d/%0d expected %0d/%0d", hz.stall_cnt, hz.flush_cnt, exp_stall, exp_flush); end
  endtask

  task automatic test_back_to_back();
    tick(); drive(5'd4, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0); #3;
    show("b2b_luh");
    checks++; if (outs() !== EXP_LUH) begin errors++; $display("FAIL b2b_luh: got %b expected %b", outs(), EXP_LUH); end
    exp_stall += 32'(PERF);
    tick(); drive(5'd6, 5'd0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0); #3;
    show("b2b_mst_luh");
    checks++; if (outs() !== EXP_MST) begin errors++; $display("FAIL b2b_mst_luh: got %b expected %b", outs(), EXP_MST); end
    exp_stall += 32'(PERF);
    tick(); drive(5'd6, 5'd0, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0); #3;
    show("b2b_ready_luh");
    checks++; if (outs() !== EXP_LUH) begin errors++; $display("FAIL b2b_ready_luh: got %b expected %b", outs(), EXP_LUH); end
    exp_stall += 32'(PERF);
    tick(); drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1); #3;
    show("b2b_br");
    checks++; if (outs() !== EXP_BR) begin errors++; $display("FAIL b2b_br: got %b expected %b", outs(), EXP_BR); end
    exp_flush += 32'(PERF);
    tick(); drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); #3;
    show("b2b_idle");
    checks++; if (outs() !== EXP_IDLE) begin errors++; $display("FAIL b2b_idle: got %b expected %b", outs(), EXP_IDLE); end
    checks++; if (hz.flush_cnt !== exp_flush || hz.stall_cnt !== exp_stall) begin errors++; $display("FAIL b2b_counts: got %0d/%0d expected %0d/%0d", hz.stall_cnt, hz.flush_cnt, exp_stall, exp_flush); end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 4; i++) begin
      tick(); drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); #3;
      show("to_wait");
      checks++; if (outs() !== EXP_MST) begin errors++; $display("FAIL to_wait_%0d: got %b expected %b", i, outs(), EXP_MST); end
      exp_stall += 32'(PERF);
    end
    tick(); #3;
    show("to_halt");
    checks++; if (outs() !== EXP_HALT) begin errors++; $display("FAIL to_halt: got %b expected %b", outs(), EXP_HALT); end
    checks++; if (hz.stall_cnt !== exp_stall) begin errors++; $display("FAIL to_stall_cnt: got %0d expected %0d", hz.stall_cnt, exp_stall); end
    tick(); drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    tick(); #3;
    show("to_ready_held");
    checks++; if (outs() !== EXP_HALT) begin errors++; $display("FAIL to_sticky: got %b expected %b", outs(), EXP_HALT); end
    checks++; if (hz.stall_cnt !== exp_stall || hz.flush_cnt !== exp_flush) begin errors++; $display("FAIL to_halt_counts: got %0d/%0d expected %0d/%0d", hz.stall_cnt, hz.flush_cnt, exp_stall, exp_flush); end
    reset = 1'b1;
    #1;
    show("to_reset");
    checks++; if (outs() !== EXP_RST) begin errors++; $display("FAIL to_reset: got %b expected %b", outs(), EXP_RST); end
    checks++; if (hz.stall_cnt !== 32'd0 || hz.flush_cnt !== 32'd0) begin errors++; $display("FAIL to_reset_cnt: got %0d/%0d expected 0/0", hz.stall_cnt, hz.flush_cnt); end
    exp_stall = 0;
    exp_flush = 0;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    show("to_release");
    checks++; if (outs() !== EXP_IDLE) begin errors++; $display("FAIL to_release: got %b expected %b", outs(), EXP_IDLE); end
  endtask

  task automatic test_reset_mid_mwait();
    tick(); drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); #3;
    show("rmw_wait");
    checks++; if (outs() !== EXP_MST) begin errors++; $display("FAIL rmw_wait: got %b expected %b", outs(), EXP_MST); end
    tick();
    reset = 1'b1;
    #1;
    show("rmw_reset");
    checks++; if (outs() !== EXP_RST) begin errors++; $display("FAIL rmw_reset: got %b expected %b", outs(), EXP_RST); end
    checks++; if (hz.stall_cnt !== 32'd0) begin errors++; $display("FAIL rmw_reset_cnt: got %0d expected 0", hz.stall_cnt); end
    exp_stall = 0;
    exp_flush = 0;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    show("rmw_release");
    checks++; if (outs() !== EXP_IDLE) begin errors++; $display("FAIL rmw_release: got %b expected %b", outs(), EXP_IDLE); end
    tick(); #3;
    show("rmw_first");
    checks++; if (outs() !== EXP_IDLE) begin errors++; $display("FAIL rmw_first: got %b expected %b", outs(), EXP_IDLE); end
    checks++; if (hz.stall_cnt !== exp_stall || hz.flush_cnt !== exp_flush) begin errors++; $display("FAIL rmw_counts: got %0d/%0d expected %0d/%0d", hz.stall_cnt, hz.flush_cnt, exp_stall, exp_flush); end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    exp_stall = 0;
    exp_flush = 0;
    test_reset();
    test_load_use();
    test_mem_wait();
    test_branch_luh();
    test_branch_during_stall();
    test_back_to_back();
    test_timeout();
    test_reset_mid_mwait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion before 100000");
    $fatal(1);
  end

endmodule
